cam_capture_rgb565: RTL
=======================

# cam_capture_rgb565

Writer side of the frame-buffer pixel path: samples an OV7670-style 8-bit camera bus (pclk/href/vsync/data), pairs bytes into RGB565 pixels, and issues single-cycle writes with linear addresses into the frame buffer. The image signal processor and VGA layer mux read that buffer as `bg_data`. Frame capture is gated by a control enable. Each completed frame produces a done pulse plus sticky error flags.

## Interface
- `H_ACTIVE`, 320: pixels per line written to the buffer
- `V_ACTIVE`, 240: lines per frame written to the buffer
- `ADDR_W`, 17: frame-buffer address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE

- `clk`  in  1  system clock; all logic on rising edge; must be ≥ 4× cam_pclk frequency
- `reset`  in  1  synchronous, active-high
- `cam_pclk`  in  1  camera pixel clock, asynchronous; treated as data
- `cam_vsync`  in  1  camera frame sync; high = vertical blanking
- `cam_href`  in  1  camera line valid
- `cam_data`  in  8  camera byte
- `capture_en`  in  1  level; start or continue capturing frames
- `wr_en`  out  1  one-cycle write strobe
- `wr_addr`  out  ADDR_W  linear address, line·H_ACTIVE + col
- `wr_data`  out  16  RGB565 pixel, first byte in [15:8]
- `frame_done`  out  1  one-cycle pulse at end of each captured frame
- `busy`  out  1  high in WAIT_VSYNC and CAPTURE
- `err_line`  out  1  sticky: a line ended with an odd byte count or a pixel count ≠ H_ACTIVE
- `err_frame`  out  1  sticky: a frame ended with a line count ≠ V_ACTIVE

## Operation
- `cam_pclk`, `cam_href`, `cam_vsync` and `cam_data` pass through identical 2-FF synchronisers so they stay aligned.
- A rising edge of synchronised pclk forms `byte_stb`. Edges of href and vsync are detected from the same pipeline.
- States:
  - IDLE: wait for `capture_en`=1, then go to WAIT_VSYNC.
  - WAIT_VSYNC: on a vsync falling edge, go to CAPTURE. Clear line, column and byte-phase counters.
  - CAPTURE: capture pixels. On a vsync rising edge, go to DONE.
  - DONE: one cycle. Assert `frame_done`. Go to WAIT_VSYNC if `capture_en`, else IDLE.
- `capture_en` deasserting mid-frame does not abort; the current frame completes.
- In CAPTURE, on `byte_stb` with href=1:
  - Phase 0: latch byte into hi[7:0].
  - Phase 1: build pixel {hi, byte}. Write it if col < H_ACTIVE and line < V_ACTIVE. Increment col.
- Excess pixels or lines are dropped silently. The address never exceeds H_ACTIVE·V_ACTIVE−1.
- href rising edge: byte phase ← 0, col ← 0.
- href falling edge: line increments if col > 0. `err_line` sets if phase = 1 or col ≠ H_ACTIVE.
- DONE: `err_frame` sets if line ≠ V_ACTIVE.
- Error flags clear only on `reset` or on the IDLE→WAIT_VSYNC transition.
- Address is computed incrementally: `wr_addr` ← base + col, where base increases by H_ACTIVE per completed line. No multiplier.
- Simultaneous href falling edge and vsync rising edge: complete the line bookkeeping first, then the frame check uses the updated line count.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `busy`=0, `err_line`=0, `err_frame`=0. State = IDLE. Synchroniser flops = 0.
- Write latency: `wr_en` asserts exactly 3 clk cycles after the first clk edge that samples `cam_pclk`=1 for the second byte.
- `wr_addr` and `wr_data` are valid in the same cycle as `wr_en`.
- `wr_en` is never high on two consecutive cycles. `frame_done` asserts 3 cycles after vsync is first sampled high.
- `reset` mid-frame: all outputs return to reset values on the next edge. No write is issued from a partial pixel.

## Structure
- `cam_capture_pkg`:
  - `cap_state_t` enum {IDLE, WAIT_VSYNC, CAPTURE, DONE}
  - default constants `H_ACTIVE_DEF`=320, `V_ACTIVE_DEF`=240
- One sub-module, `sync_edge`, instantiated per control signal: 2-FF synchroniser plus registered previous value, with outputs level, rise and fall. `cam_data` uses a plain 2-stage register.

## Test plan
- Nominal 4×3 frame (H_ACTIVE=4, V_ACTIVE=3), bytes 0x00..0x17 → 12 writes at addresses 0..11, first `wr_data`=0x0001, last 0x1617. One `frame_done`, both error flags 0.
- Line with 5 pixels (H_ACTIVE=4) → only addresses 0..3 written, 5th pixel dropped, `err_line`=1.
- Line ending with an odd byte (9 bytes) → the 9th byte never written, `err_line`=1, next line starts at base 4 with phase 0.
- Frame with 2 lines (V_ACTIVE=3) → 8 writes, `frame_done` pulse, `err_frame`=1. A following good frame restarts at address 0.
- `capture_en` dropped mid-frame → frame completes with 12 writes, state returns to IDLE, no writes on the next frame.
- `reset` asserted between the first and second byte of pixel 5 → no write occurs. After release and re-enable, capture restarts at address 0 on the next vsync falling edge.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Shared types and default geometry for the camera capture path.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitVsync,
    StCapture,
    StDone
  } cap_state_t;

  localparam int unsigned H_ACTIVE_DEF = 320;
  localparam int unsigned V_ACTIVE_DEF = 240;

endpackage

// File: rtl/cam_capture_rgb565_sync_edge.sv
// Two-flop synchroniser with a registered previous value for edge detection.
module sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Synchroniser chain plus one-cycle-delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/cam_capture_rgb565.sv
// Samples an 8-bit camera bus, pairs bytes into RGB565 pixels and writes them
// to a linear frame buffer, with per-frame done pulse and sticky error flags.
module cam_capture_rgb565
  import cam_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              err_line,
  output logic              err_frame
);

  // Counters saturate one past the active size so overruns stay detectable
  localparam int unsigned ColW  = $clog2(H_ACTIVE + 2);
  localparam int unsigned LineW = $clog2(V_ACTIVE + 2);
  localparam logic [ColW-1:0]   ColMax   = ColW'(H_ACTIVE);
  localparam logic [LineW-1:0]  LineMax  = LineW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE);

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vsync_lvl, vsync_rise, vsync_fall;
  logic unused_sync;

  sync_edge u_sync_pclk (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (cam_pclk),
    .level_o (pclk_lvl),
    .rise_o  (pclk_rise),
    .fall_o  (pclk_fall)
  );

  sync_edge u_sync_href (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (cam_href),
    .level_o (href_lvl),
    .rise_o  (href_rise),
    .fall_o  (href_fall)
  );

  sync_edge u_sync_vsync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (cam_vsync),
    .level_o (vsync_lvl),
    .rise_o  (vsync_rise),
    .fall_o  (vsync_fall)
  );

  assign unused_sync = pclk_lvl ^ pclk_fall ^ vsync_lvl;

  logic [7:0] data_meta_q, data_sync_q;
  logic       byte_stb;

  assign byte_stb = pclk_rise & href_lvl;

  cap_state_t        state_q, state_d;
  logic              phase_q, phase_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        hi_q, hi_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [15:0]       req_data_q, req_data_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              err_line_q, err_line_d;
  logic              err_frame_q, err_frame_d;

  // Next-state: frame FSM, pixel assembly, line bookkeeping, write staging
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    col_d        = col_q;
    line_d       = line_q;
    base_d       = base_q;
    hi_d         = hi_q;
    req_d        = 1'b0;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    wr_en_d      = req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_line_d   = err_line_q;
    err_frame_d  = err_frame_q;

    // Extra stage so the strobe lands three cycles after the sampled pclk edge
    if (req_q) begin
      wr_addr_d = req_addr_q;
      wr_data_d = req_data_q;
    end

    unique case (state_q)
      StIdle: begin
        if (capture_en) begin
          state_d     = StWaitVsync;
          err_line_d  = 1'b0;
          err_frame_d = 1'b0;
        end
      end
      StWaitVsync: begin
        phase_d = 1'b0;
        col_d   = '0;
        line_d  = '0;
        base_d  = '0;
        if (vsync_fall) state_d = StCapture;
      end
      StCapture: begin
        if (href_rise) begin
          phase_d = 1'b0;
          col_d   = '0;
        end
        if (byte_stb) begin
          if (!phase_d) begin
            hi_d    = data_sync_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_d < ColMax && line_q < LineMax) begin
              req_d      = 1'b1;
              req_addr_d = base_q + ADDR_W'(col_d);
              req_data_d = {hi_q, data_sync_q};
            end
            if (col_d <= ColMax) col_d = col_d + ColW'(1);
          end
        end
        // Line bookkeeping settles here so a same-cycle vsync sees the new count
        if (href_fall) begin
          if (col_q != '0) begin
            if (line_q <= LineMax) line_d = line_q + LineW'(1);
            if (line_q < LineMax) base_d = base_q + LineStep;
          end
          if (phase_q || col_q != ColMax) err_line_d = 1'b1;
        end
        if (vsync_rise) state_d = StDone;
      end
      StDone: begin
        frame_done_d = 1'b1;
        if (line_q != LineMax) err_frame_d = 1'b1;
        state_d = capture_en ? StWaitVsync : StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWaitVsync) || (state_d == StCapture);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta_q  <= '0;
      data_sync_q  <= '0;
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      base_q       <= '0;
      hi_q         <= '0;
      req_q        <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      data_meta_q  <= cam_data;
      data_sync_q  <= data_meta_q;
      state_q      <= state_d;
      phase_q      <= phase_d;
      col_q        <= col_d;
      line_q       <= line_d;
      base_q       <= base_d;
      hi_q         <= hi_d;
      req_q        <= req_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;

endmodule
